// File: rtl/cnn_pkg.sv
// Shared CNN front-end definitions: pixel width, default frame size and the
// feeder FSM state encoding.
package cnn_pkg;

    localparam int PIXEL_W              = 8;
    localparam int DEFAULT_FRAME_PIXELS = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_STREAM,
        ST_DRAIN,
        ST_WAIT_RESULT
    } feeder_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data and asynchronous active-high reset.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/pixel_frame_feeder.sv
// Buffers host pixels and feeds exactly FRAME_PIXELS pixels per frame to the CNN,
// padding short frames and draining over-long ones. FEEDER_STATS_EN adds counters.
module pixel_frame_feeder
    import cnn_pkg::*;
#(
    parameter int FRAME_PIXELS = DEFAULT_FRAME_PIXELS,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    input  logic [PIXEL_W-1:0] s_data,
    input  logic               s_last,
    output logic               s_ready,
    output logic               start_signal,
    output logic               pixel_valid,
    output logic [PIXEL_W-1:0] pixel_in,
    input  logic               result_valid,
    output logic               busy,
    output logic               frame_error,
    output feeder_state_t      state_dbg
`ifdef FEEDER_STATS_EN
    ,
    output logic [15:0]        frame_count,
    output logic [15:0]        error_count
`endif
);

    localparam int CW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_PIXELS - 1);

    // Handshake: a host pixel transfers on a cycle where s_valid && s_ready;
    // s_ready is simply "FIFO not full", so data is taken in every FSM state.
    feeder_state_t      state, state_d;
    logic [CW-1:0]      cnt, cnt_d;
    logic               pad, pad_d;
    logic               pv_d, err_d;
    logic [PIXEL_W-1:0] pix_d;
    logic               fifo_pop, fifo_full, fifo_empty;
    logic [PIXEL_W:0]   fifo_dout;
    logic               fifo_last;

    sync_fifo #(
        .WIDTH (PIXEL_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s_valid),
        .din   ({s_last, s_data}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign fifo_last    = fifo_dout[PIXEL_W];
    assign s_ready      = !fifo_full;
    assign start_signal = (state == ST_START);
    assign busy         = (state != ST_IDLE);
    assign state_dbg    = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            pad         <= 1'b0;
            pixel_valid <= 1'b0;
            pixel_in    <= '0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            pad         <= pad_d;
            pixel_valid <= pv_d;
            pixel_in    <= pix_d;
            frame_error <= err_d;
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        pad_d    = pad;
        pv_d     = 1'b0;
        pix_d    = '0;
        err_d    = 1'b0;
        fifo_pop = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_START;
            end
            ST_START: begin
                cnt_d   = '0;
                pad_d   = 1'b0;
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                // After an early last the frame is completed with zero pixels.
                if (pad) begin
                    pv_d  = 1'b1;
                    cnt_d = cnt + CW'(1);
                    if (cnt == LAST_IDX) state_d = ST_WAIT_RESULT;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    pv_d     = 1'b1;
                    pix_d    = fifo_dout[PIXEL_W-1:0];
                    cnt_d    = cnt + CW'(1);
                    if (cnt == LAST_IDX) begin
                        err_d   = !fifo_last;
                        state_d = fifo_last ? ST_WAIT_RESULT : ST_DRAIN;
                    end else if (fifo_last) begin
                        err_d = 1'b1;
                        pad_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (fifo_last) state_d = ST_WAIT_RESULT;
                end
            end
            ST_WAIT_RESULT: begin
                if (result_valid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef FEEDER_STATS_EN
    // frame_count wraps; error_count saturates so a flood of errors stays visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count <= '0;
            error_count <= '0;
        end else begin
            if (state == ST_WAIT_RESULT && result_valid) frame_count <= frame_count + 16'd1;
            if (frame_error && error_count != 16'hFFFF) error_count <= error_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pixel_frame_feeder.sv
// Directed bench for pixel_frame_feeder: table of frame scenarios plus hand-written
// sequences for WAIT_RESULT back-pressure and mid-frame reset.
module tb_pixel_frame_feeder;
    import cnn_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = '0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic          start_signal;
    logic          pixel_valid;
    logic [7:0]    pixel_in;
    logic          result_valid = 1'b0;
    logic          busy;
    logic          frame_error;
    feeder_state_t state_dbg;
`ifdef FEEDER_STATS_EN
    logic [15:0]   frame_count;
    logic [15:0]   error_count;
`endif

    pixel_frame_feeder #(
        .FRAME_PIXELS (1024),
        .FIFO_DEPTH   (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .start_signal (start_signal),
        .pixel_valid  (pixel_valid),
        .pixel_in     (pixel_in),
        .result_valid (result_valid),
        .busy         (busy),
        .frame_error  (frame_error),
        .state_dbg    (state_dbg)
`ifdef FEEDER_STATS_EN
        ,
        .frame_count  (frame_count),
        .error_count  (error_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string name;
        int    n_pix;
        int    last_at;
        bit    toggle;
        bit    rv_hi;
        int    exp_pv;
        int    exp_err;
        int    exp_err_idx;
    } frame_vec_t;

    frame_vec_t vecs [5];

    int n_vec = 0;
    int n_err = 0;
    int start_cnt, pv_cnt, err_cnt, err_idx, pix_bad;
    int exp_frames = 0;
    int exp_errs = 0;
    bit hs;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: observe outputs at the falling edge, then return 1ns after the rising edge.
    task automatic step();
        logic [7:0] e;
        @(negedge clk);
        if (start_signal) start_cnt++;
        if (frame_error) begin
            err_cnt++;
            err_idx = pixel_valid ? pv_cnt : -2;
        end
        if (pixel_valid) begin
            if (exp_q.size() == 0) pix_bad++;
            else begin
                e = exp_q.pop_front();
                if (pixel_in !== e) pix_bad++;
            end
            pv_cnt++;
        end
        hs = s_valid && s_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        start_cnt = 0;
        pv_cnt    = 0;
        err_cnt   = 0;
        err_idx   = -1;
        pix_bad   = 0;
    endtask

    task automatic drive(input int from, input int to, input int last_at,
                         input bit toggle, input bit rv_hi);
        int  i = from;
        int  budget = 20000;
        bit  ph = 1'b1;
        while (i < to && budget > 0) begin
            s_valid      = toggle ? ph : 1'b1;
            ph           = ~ph;
            s_data       = 8'(i);
            s_last       = (i == last_at);
            result_valid = rv_hi;
            step();
            if (hs) i++;
            budget--;
        end
        s_valid      = 1'b0;
        s_last       = 1'b0;
        result_valid = 1'b0;
        check("drive_done", i, to);
    endtask

    task automatic wait_result_state(input string name);
        int budget = 4000;
        while (state_dbg != ST_WAIT_RESULT && budget > 0) begin
            step();
            budget--;
        end
        check({name, ":reach_wait"}, int'(state_dbg == ST_WAIT_RESULT), 1);
        step();
    endtask

    task automatic pulse_result();
        result_valid = 1'b1;
        step();
        result_valid = 1'b0;
        exp_frames++;
    endtask

    task automatic check_stats(input string name);
`ifdef FEEDER_STATS_EN
        check({name, ":frame_count"}, int'(frame_count), exp_frames);
        check({name, ":error_count"}, int'(error_count), exp_errs);
`else
        if (name.len() < 0) $display("%s", name);
`endif
    endtask

    task automatic run_vec(input frame_vec_t v);
        clear_mon();
        exp_q.delete();
        for (int k = 0; k < 1024; k++) begin
            if (k < v.n_pix && (v.last_at >= 1023 || k <= v.last_at)) exp_q.push_back(8'(k));
            else exp_q.push_back(8'h00);
        end
        drive(0, v.n_pix, v.last_at, v.toggle, v.rv_hi);
        wait_result_state(v.name);
        check({v.name, ":start_pulses"}, start_cnt, 1);
        check({v.name, ":pixel_valid_total"}, pv_cnt, v.exp_pv);
        check({v.name, ":pixel_values_bad"}, pix_bad, 0);
        check({v.name, ":frame_error_pulses"}, err_cnt, v.exp_err);
        check({v.name, ":frame_error_index"}, err_idx, v.exp_err_idx);
        exp_errs += v.exp_err;
        pulse_result();
        check({v.name, ":busy_after_result"}, int'(busy), 0);
        repeat (5) step();
        check({v.name, ":no_restart_fifo_empty"}, start_cnt, 1);
        check({v.name, ":idle_state"}, int'(state_dbg), int'(ST_IDLE));
        check_stats(v.name);
    endtask

    initial begin
        int acc;
        int base;
        int budget;

        vecs[0] = '{"clean",        1024, 1023, 1'b0, 1'b0, 1024, 0, -1};
        vecs[1] = '{"toggle",       1024, 1023, 1'b1, 1'b1, 1024, 0, -1};
        vecs[2] = '{"early_last",    500,  499, 1'b0, 1'b0, 1024, 1, 499};
        vecs[3] = '{"no_last",      1027, 1026, 1'b0, 1'b0, 1024, 1, 1023};
        vecs[4] = '{"last_at_1022", 1023, 1022, 1'b0, 1'b0, 1024, 1, 1022};

        // Reset state while rst is held.
        repeat (3) @(posedge clk);
        #1;
        check("rst:pixel_valid", int'(pixel_valid), 0);
        check("rst:pixel_in", int'(pixel_in), 0);
        check("rst:start_signal", int'(start_signal), 0);
        check("rst:frame_error", int'(frame_error), 0);
        check("rst:busy", int'(busy), 0);
        check("rst:s_ready", int'(s_ready), 1);
        check("rst:state", int'(state_dbg), int'(ST_IDLE));
        check_stats("rst");
        rst = 1'b0;
        clear_mon();
        repeat (3) step();

        for (int v = 0; v < 5; v++) run_vec(vecs[v]);

        // Host keeps streaming while the feeder waits for the CNN result.
        clear_mon();
        exp_q.delete();
        for (int k = 0; k < 1024; k++) exp_q.push_back(8'(k));
        drive(0, 1024, 1023, 1'b0, 1'b0);
        wait_result_state("bp_first");
        check("bp_first:pixel_values_bad", pix_bad, 0);
        clear_mon();
        for (int k = 0; k < 1024; k++) exp_q.push_back(8'(k));
        acc = 0;
        for (int c = 0; c < 30; c++) begin
            s_valid = 1'b1;
            s_data  = 8'(acc);
            s_last  = 1'b0;
            step();
            if (hs) acc++;
        end
        check("bp:accepted_until_full", acc, 16);
        check("bp:s_ready_low", int'(s_ready), 0);
        check("bp:no_pixels_in_wait", pv_cnt, 0);
        check("bp:no_start_in_wait", start_cnt, 0);
        check("bp:still_wait", int'(state_dbg), int'(ST_WAIT_RESULT));
        s_valid = 1'b0;
        pulse_result();
        drive(16, 1024, 1023, 1'b0, 1'b0);
        wait_result_state("bp_second");
        check("bp_second:start_pulses", start_cnt, 1);
        check("bp_second:pixel_valid_total", pv_cnt, 1024);
        check("bp_second:pixel_values_bad", pix_bad, 0);
        check("bp_second:frame_error_pulses", err_cnt, 0);
        pulse_result();
        repeat (3) step();
        check_stats("bp");

        // Asynchronous reset in the middle of a frame.
        clear_mon();
        exp_q.delete();
        for (int k = 0; k < 1024; k++) exp_q.push_back(8'(k));
        acc = 0;
        budget = 2000;
        while (pv_cnt < 300 && budget > 0) begin
            s_valid = 1'b1;
            s_data  = 8'(acc);
            s_last  = 1'b0;
            step();
            if (hs) acc++;
            budget--;
        end
        check("mid_rst:reached_300", int'(pv_cnt >= 300), 1);
        s_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst:pixel_valid", int'(pixel_valid), 0);
        check("mid_rst:pixel_in", int'(pixel_in), 0);
        check("mid_rst:start_signal", int'(start_signal), 0);
        check("mid_rst:frame_error", int'(frame_error), 0);
        check("mid_rst:busy", int'(busy), 0);
        check("mid_rst:s_ready", int'(s_ready), 1);
        check("mid_rst:state", int'(state_dbg), int'(ST_IDLE));
        exp_frames = 0;
        exp_errs   = 0;
        check_stats("mid_rst");
        check("mid_rst:prefix_bad", pix_bad, 0);
        step();
        rst = 1'b0;
        exp_q.delete();
        base = pv_cnt;
        acc  = start_cnt;
        repeat (20) step();
        check("post_rst:no_pixels", pv_cnt, base);
        check("post_rst:no_start", start_cnt, acc);
        check("post_rst:idle", int'(busy), 0);
        check("post_rst:s_ready", int'(s_ready), 1);

        run_vec(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
